// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter
// Owns the TinyBF program memory ports. It sequences host program download
// (a byte stream turned into auto-incrementing writes), runs the mode FSM
// that holds the CPU while loading or idle, and shares the single memory
// read port between CPU instruction fetch and host readback.
// The memory itself lives outside this block and has a 1-cycle read latency
// with write-first behaviour for same-address write and read.

module program_mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // Mode control pulses from the host
    input  logic              load_start_i,
    input  logic              load_end_i,
    input  logic              run_i,
    input  logic              halt_i,

    // Host download stream
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic [AW:0]       load_len_o,

    // CPU gating
    output logic              cpu_hold_o,

    // CPU instruction fetch
    input  logic              fetch_req_i,
    input  logic [AW-1:0]     fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_data_o,

    // Host readback / verify
    input  logic              rb_req_i,
    input  logic [AW-1:0]     rb_addr_i,
    output logic              rb_gnt_o,
    output logic              rb_valid_o,
    output logic [DATA_W-1:0] rb_data_o,

    // Program memory write port
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,

    // Program memory read port
    output logic              mem_ren_o,
    output logic [AW-1:0]     mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   wptr_q;
    logic [AW:0]     len_q;
    logic            load_done_q;
    logic            load_done_d;
    logic            fetch_valid_q;
    logic            rb_valid_q;
    logic            byte_accept;
    logic            last_accept;

    // A host byte is taken only while loading and no control pulse competes.
    always_comb begin
        load_ready_o = (state_q == ST_LOAD) && !load_start_i && !load_end_i;
        byte_accept  = load_valid_i && load_ready_o;
        last_accept  = byte_accept && (wptr_q == LAST_ADDR);
    end

    // Mode FSM next state; the done pulse is raised for whichever exit leaves LOAD.
    always_comb begin
        state_d     = state_q;
        load_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end else if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end else if (load_end_i || last_accept) begin
                    state_d     = ST_IDLE;
                    load_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end else if (halt_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Mode state register and the one-cycle load-done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
        end
    end

    // Write pointer and length; the pointer may wrap after the last slot but
    // the length saturates naturally at DEPTH because LOAD exits there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            len_q  <= '0;
        end else if (load_start_i) begin
            wptr_q <= '0;
            len_q  <= '0;
        end else if (byte_accept) begin
            wptr_q <= wptr_q + PTR_ONE;
            len_q  <= len_q + LEN_ONE;
        end
    end

    // Accepted bytes go straight to the memory write port.
    always_comb begin
        mem_wen_o   = byte_accept;
        mem_waddr_o = wptr_q;
        mem_wdata_o = load_data_i;
    end

    // Fixed-priority read arbitration: fetch wins, and only while running.
    always_comb begin
        fetch_gnt_o = fetch_req_i && (state_q == ST_RUN);
        rb_gnt_o    = rb_req_i && !fetch_gnt_o;
        mem_ren_o   = fetch_gnt_o || rb_gnt_o;
        mem_raddr_o = fetch_gnt_o ? fetch_addr_i : rb_addr_i;
    end

    // Track which requester owns the read that returns next cycle; this is
    // independent of the mode so an in-flight read always completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_valid_q <= 1'b0;
            rb_valid_q    <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_gnt_o;
            rb_valid_q    <= rb_gnt_o;
        end
    end

    // Status outputs and shared read-data return.
    always_comb begin
        load_done_o   = load_done_q;
        load_len_o    = len_q;
        cpu_hold_o    = (state_q != ST_RUN);
        fetch_valid_o = fetch_valid_q;
        rb_valid_o    = rb_valid_q;
        fetch_data_o  = mem_rdata_i;
        rb_data_o     = mem_rdata_i;
    end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// tb_program_mem_arbiter
// Table-driven bench for program_mem_arbiter with a small write-first,
// 1-cycle-latency program memory attached to its ports.

module tb_program_mem_arbiter;

    logic       clk_i;
    logic       rst_i;
    logic       load_start_i, load_end_i, run_i, halt_i;
    logic       load_valid_i;
    logic [7:0] load_data_i;
    logic       load_ready_o, load_done_o;
    logic [4:0] load_len_o;
    logic       cpu_hold_o;
    logic       fetch_req_i;
    logic [3:0] fetch_addr_i;
    logic       fetch_gnt_o, fetch_valid_o;
    logic [7:0] fetch_data_o;
    logic       rb_req_i;
    logic [3:0] rb_addr_i;
    logic       rb_gnt_o, rb_valid_o;
    logic [7:0] rb_data_o;
    logic       mem_wen_o;
    logic [3:0] mem_waddr_o;
    logic [7:0] mem_wdata_o;
    logic       mem_ren_o;
    logic [3:0] mem_raddr_o;
    logic [7:0] mem_rdata_i;

    program_mem_arbiter #(.DATA_W(8), .DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .load_start_i(load_start_i), .load_end_i(load_end_i),
        .run_i(run_i), .halt_i(halt_i),
        .load_valid_i(load_valid_i), .load_data_i(load_data_i),
        .load_ready_o(load_ready_o), .load_done_o(load_done_o),
        .load_len_o(load_len_o), .cpu_hold_o(cpu_hold_o),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_valid_o(fetch_valid_o),
        .fetch_data_o(fetch_data_o),
        .rb_req_i(rb_req_i), .rb_addr_i(rb_addr_i),
        .rb_gnt_o(rb_gnt_o), .rb_valid_o(rb_valid_o), .rb_data_o(rb_data_o),
        .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Clock generation
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Program memory: write-first, registered read
    logic [7:0] mem_model [16];
    always @(posedge clk_i) begin
        if (mem_wen_o) mem_model[mem_waddr_o] <= mem_wdata_o;
        if (mem_ren_o) mem_rdata_i <= (mem_wen_o && mem_waddr_o == mem_raddr_o)
                                      ? mem_wdata_o : mem_model[mem_raddr_o];
    end

    // Stimulus control bits {rst, load_start, load_end, run, halt, load_valid, fetch_req, rb_req}
    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_RST  = 8'h80;
    localparam logic [7:0] C_LS   = 8'h40;
    localparam logic [7:0] C_LE   = 8'h20;
    localparam logic [7:0] C_RUN  = 8'h10;
    localparam logic [7:0] C_HALT = 8'h08;
    localparam logic [7:0] C_LV   = 8'h04;
    localparam logic [7:0] C_FR   = 8'h02;
    localparam logic [7:0] C_RR   = 8'h01;

    // Expected flag bits {ready, done, hold, fetch_gnt, fetch_valid, rb_gnt, rb_valid, wen, ren}
    localparam logic [8:0] F_RDY  = 9'h100;
    localparam logic [8:0] F_DONE = 9'h080;
    localparam logic [8:0] F_HOLD = 9'h040;
    localparam logic [8:0] F_FGNT = 9'h020;
    localparam logic [8:0] F_FV   = 9'h010;
    localparam logic [8:0] F_RGNT = 9'h008;
    localparam logic [8:0] F_RV   = 9'h004;
    localparam logic [8:0] F_WEN  = 9'h002;
    localparam logic [8:0] F_REN  = 9'h001;

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] ld;
        logic [3:0] fa;
        logic [3:0] ra;
        logic [8:0] flags;
        logic [4:0] len;
        logic [3:0] ew;
        logic [3:0] er;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];
    int   vectors_applied;
    int   miscompares;

    function automatic vec_t mk(input logic [7:0] ctrl, input logic [7:0] ld,
                                input logic [3:0] fa, input logic [3:0] ra,
                                input logic [8:0] flags, input logic [4:0] len,
                                input logic [3:0] ew, input logic [3:0] er,
                                input logic [7:0] data);
        vec_t v;
        v.ctrl = ctrl; v.ld = ld; v.fa = fa; v.ra = ra;
        v.flags = flags; v.len = len; v.ew = ew; v.er = er; v.data = data;
        return v;
    endfunction

    // Compare every output group against the record
    task automatic check_output(input vec_t v, input int idx);
        logic [8:0] act;
        act = {load_ready_o, load_done_o, cpu_hold_o, fetch_gnt_o, fetch_valid_o,
               rb_gnt_o, rb_valid_o, mem_wen_o, mem_ren_o};
        vectors_applied++;
        if (act !== v.flags) begin
            miscompares++;
            $display("[TB] FAIL vec %0d flags: got %b expected %b", idx, act, v.flags);
        end
        if (load_len_o !== v.len) begin
            miscompares++;
            $display("[TB] FAIL vec %0d load_len: got %0d expected %0d", idx, load_len_o, v.len);
        end
        if (v.flags[1] && (mem_waddr_o !== v.ew || mem_wdata_o !== v.ld)) begin
            miscompares++;
            $display("[TB] FAIL vec %0d write: got addr %0d data %h expected addr %0d data %h",
                     idx, mem_waddr_o, mem_wdata_o, v.ew, v.ld);
        end
        if (v.flags[0] && mem_raddr_o !== v.er) begin
            miscompares++;
            $display("[TB] FAIL vec %0d raddr: got %0d expected %0d", idx, mem_raddr_o, v.er);
        end
        if (v.flags[4] && fetch_data_o !== v.data) begin
            miscompares++;
            $display("[TB] FAIL vec %0d fetch_data: got %h expected %h", idx, fetch_data_o, v.data);
        end
        if (v.flags[2] && rb_data_o !== v.data) begin
            miscompares++;
            $display("[TB] FAIL vec %0d rb_data: got %h expected %h", idx, rb_data_o, v.data);
        end
    endtask

    // Drive one record on the falling edge and check once inputs settle
    task automatic apply_stimulus(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_i        = v.ctrl[7];
        load_start_i = v.ctrl[6];
        load_end_i   = v.ctrl[5];
        run_i        = v.ctrl[4];
        halt_i       = v.ctrl[3];
        load_valid_i = v.ctrl[2];
        fetch_req_i  = v.ctrl[1];
        rb_req_i     = v.ctrl[0];
        load_data_i  = v.ld;
        fetch_addr_i = v.fa;
        rb_addr_i    = v.ra;
        #1;
        if (!v.ctrl[7]) check_output(v, idx);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
        mem_rdata_i = 8'h00;

        // Reset state
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd0, 4'd0, 4'd0, 8'h00));

        // Full 16-byte load, one byte per cycle
        tbl.push_back(mk(C_LS, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd0, 4'd0, 4'd0, 8'h00));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(C_LV, 8'(8'h10 + i), 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN,
                             5'(i), 4'(i), 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'h99, 4'd0, 4'd0, F_DONE | F_HOLD, 5'd16, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd16, 4'd0, 4'd0, 8'h00));
        // Verify via readback in IDLE
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'(k),
                             F_HOLD | F_RGNT | F_REN | ((k > 0) ? F_RV : 9'h000),
                             5'd16, 4'd0, 4'(k), 8'(8'h0F + k)));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD | F_RV, 5'd16, 4'd0, 4'd0, 8'h1F));

        // Short load ended early
        tbl.push_back(mk(C_LS, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd16, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'hA0, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'hA1, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd1, 4'd1, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'hA2, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd2, 4'd2, 4'd0, 8'h00));
        tbl.push_back(mk(C_LE | C_LV, 8'hEE, 4'd0, 4'd0, F_HOLD, 5'd3, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd3, F_DONE | F_HOLD | F_RGNT | F_REN, 5'd3, 4'd0, 4'd3, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd15, F_HOLD | F_RGNT | F_REN | F_RV, 5'd3, 4'd0, 4'd15, 8'h13));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd0, F_HOLD | F_RGNT | F_REN | F_RV, 5'd3, 4'd0, 4'd0, 8'h1F));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD | F_RV, 5'd3, 4'd0, 4'd0, 8'hA0));

        // RUN: fetch priority, in-flight fetch across halt, IDLE fetch blocked
        tbl.push_back(mk(C_RUN, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd3, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_FR | C_RR, 8'h00, 4'd2, 4'd5, F_FGNT | F_REN, 5'd3, 4'd0, 4'd2, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd5, F_FV | F_RGNT | F_REN, 5'd3, 4'd0, 4'd5, 8'hA2));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_RV, 5'd3, 4'd0, 4'd0, 8'h15));
        tbl.push_back(mk(C_FR, 8'h00, 4'd1, 4'd0, F_FGNT | F_REN, 5'd3, 4'd0, 4'd1, 8'h00));
        tbl.push_back(mk(C_HALT | C_FR, 8'h00, 4'd7, 4'd0, F_FGNT | F_REN | F_FV, 5'd3, 4'd0, 4'd7, 8'hA1));
        tbl.push_back(mk(C_FR | C_RR, 8'h00, 4'd7, 4'd6, F_HOLD | F_FV | F_RGNT | F_REN, 5'd3, 4'd0, 4'd6, 8'h17));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD | F_RV, 5'd3, 4'd0, 4'd0, 8'h16));

        // Same-cycle write and readback of address 4; run ignored in LOAD
        tbl.push_back(mk(C_LS, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd3, 4'd0, 4'd0, 8'h00));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(C_LV, 8'(8'h50 + i), 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN,
                             5'(i), 4'(i), 4'd0, 8'h00));
        tbl.push_back(mk(C_LV | C_RR, 8'hAB, 4'd0, 4'd4, F_RDY | F_HOLD | F_WEN | F_RGNT | F_REN,
                         5'd4, 4'd4, 4'd4, 8'h00));
        tbl.push_back(mk(C_LV, 8'h55, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN | F_RV, 5'd5, 4'd5, 4'd0, 8'hAB));
        tbl.push_back(mk(C_RUN | C_LV, 8'h56, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd6, 4'd6, 4'd0, 8'h00));

        // Reset mid-load: aborted, no done, length cleared, bytes kept
        tbl.push_back(mk(C_RST, 8'h00, 4'd0, 4'd0, 9'h000, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd6, F_HOLD | F_RGNT | F_REN, 5'd0, 4'd0, 4'd6, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd4, F_HOLD | F_RGNT | F_REN | F_RV, 5'd0, 4'd0, 4'd4, 8'h56));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_HOLD | F_RV, 5'd0, 4'd0, 4'd0, 8'hAB));

        // Restart inside LOAD, then LOAD entered from RUN
        tbl.push_back(mk(C_LS, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'h60, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LS | C_LV, 8'h61, 4'd0, 4'd0, F_HOLD, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'h62, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LE, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_DONE | F_HOLD, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_RR, 8'h00, 4'd0, 4'd0, F_HOLD | F_RGNT | F_REN, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_RUN, 8'h00, 4'd0, 4'd0, F_HOLD | F_RV, 5'd1, 4'd0, 4'd0, 8'h62));
        tbl.push_back(mk(C_LS, 8'h00, 4'd0, 4'd0, 9'h000, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LV, 8'h70, 4'd0, 4'd0, F_RDY | F_HOLD | F_WEN, 5'd0, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_LE, 8'h00, 4'd0, 4'd0, F_HOLD, 5'd1, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(C_NONE, 8'h00, 4'd0, 4'd0, F_DONE | F_HOLD, 5'd1, 4'd0, 4'd0, 8'h00));

        // Power-on reset by hand, then the table
        rst_i = 1'b1;
        load_start_i = 1'b0; load_end_i = 1'b0; run_i = 1'b0; halt_i = 1'b0;
        load_valid_i = 1'b0; load_data_i = 8'h00;
        fetch_req_i = 1'b0; fetch_addr_i = 4'd0; rb_req_i = 1'b0; rb_addr_i = 4'd0;
        repeat (3) @(posedge clk_i);

        foreach (tbl[i]) apply_stimulus(tbl[i], i);

        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
